// File: rtl/previn_cmd_ctrl.sv
// PREVIN command front end: parses framed host commands, triggers the serializer,
// waits for its frame to clock out and returns a one-byte status to the host.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | hunting for the header byte, other bytes dropped
// GET_OPC    | waiting for the opcode byte (byte timer running)
// GET_CODE   | waiting for the code byte (byte timer running)
// GET_CSUM   | waiting for the checksum byte, then validate and dispatch
// TRIG       | previn_trig held high for TRIG_WIDTH cycles
// WAIT_FRAME | counting fdata_G falling edges until the frame is complete
// RESP       | status byte presented until the host accepts it
module previn_cmd_ctrl #(
  parameter int          TRIG_WIDTH = 4,
  parameter int          FRAME_LEN  = 9,
  parameter int          TIMEOUT    = 50000,
  parameter logic [7:0]  HDR        = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       fdata_G,
  output logic [7:0] previn_code,
  output logic       previn_trig,
  output logic       busy,
  output logic [7:0] resp_data,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] err_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int EDG_W = $clog2(FRAME_LEN + 1);

  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT - 1);
  localparam logic [EDG_W-1:0] EDG_LAST  = EDG_W'(FRAME_LEN - 1);
  localparam logic [3:0]       TRIG_LOAD = 4'(TRIG_WIDTH - 1);

  localparam logic [7:0] OPC_LOAD   = 8'h01;
  localparam logic [7:0] OPC_RETRIG = 8'h02;
  localparam logic [7:0] OPC_CLEAR  = 8'h03;

  localparam logic [7:0] ST_ACK      = 8'h06;
  localparam logic [7:0] ST_BAD_CSUM = 8'h15;
  localparam logic [7:0] ST_BAD_OPC  = 8'h16;
  localparam logic [7:0] ST_BYTE_TO  = 8'h17;
  localparam logic [7:0] ST_FRAME_TO = 8'h18;

  typedef enum logic [2:0] {
    IDLE,
    GET_OPC,
    GET_CODE,
    GET_CSUM,
    TRIG,
    WAIT_FRAME,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       opc_q, opc_d;
  logic [7:0]       code_q, code_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [EDG_W-1:0] edg_q, edg_d;
  logic [3:0]       trig_cnt_q, trig_cnt_d;
  logic [7:0]       previn_code_q, previn_code_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic [7:0]       resp_data_q, resp_data_d;
  logic             resp_valid_q, resp_valid_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;

  logic       rx_acc;
  logic       fall;
  logic       resp_go;
  logic [7:0] resp_code;

  assign rx_ready = ~rst & ((state_q == IDLE) || (state_q == GET_OPC) ||
                            (state_q == GET_CODE) || (state_q == GET_CSUM));
  assign rx_acc   = rx_valid & rx_ready;

  // Edges that arrive while the load strobe is still high belong to no frame.
  assign fall = prev_q & ~sync2_q & ~trig_q;

  always_comb begin
    state_d       = state_q;
    opc_d         = opc_q;
    code_d        = code_q;
    tmr_d         = tmr_q;
    edg_d         = edg_q;
    trig_cnt_d    = trig_cnt_q;
    previn_code_d = previn_code_q;
    trig_d        = trig_q;
    busy_d        = busy_q;
    resp_data_d   = resp_data_q;
    resp_valid_d  = resp_valid_q;
    err_cnt_d     = err_cnt_q;
    sync1_d       = fdata_G;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    resp_go       = 1'b0;
    resp_code     = 8'h00;

    case (state_q)
      IDLE: begin
        if (rx_acc && (rx_data == HDR)) begin
          state_d = GET_OPC;
          tmr_d   = TMR_LOAD;
        end
      end

      GET_OPC, GET_CODE: begin
        if (rx_acc) begin
          if (state_q == GET_OPC) begin
            opc_d   = rx_data;
            state_d = GET_CODE;
          end else begin
            code_d  = rx_data;
            state_d = GET_CSUM;
          end
          tmr_d = TMR_LOAD;
        end else if (tmr_q == '0) begin
          resp_go   = 1'b1;
          resp_code = ST_BYTE_TO;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      GET_CSUM: begin
        if (rx_acc) begin
          if (rx_data != (opc_q ^ code_q)) begin
            resp_go   = 1'b1;
            resp_code = ST_BAD_CSUM;
          end else if ((opc_q != OPC_LOAD) && (opc_q != OPC_RETRIG) &&
                       (opc_q != OPC_CLEAR)) begin
            resp_go   = 1'b1;
            resp_code = ST_BAD_OPC;
          end else begin
            if (opc_q == OPC_LOAD) begin
              previn_code_d = code_q;
            end else if (opc_q == OPC_CLEAR) begin
              previn_code_d = 8'h00;
            end
            trig_d     = 1'b1;
            busy_d     = 1'b1;
            trig_cnt_d = TRIG_LOAD;
            state_d    = TRIG;
          end
        end else if (tmr_q == '0) begin
          resp_go   = 1'b1;
          resp_code = ST_BYTE_TO;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      TRIG: begin
        if (trig_cnt_q == 4'd0) begin
          trig_d  = 1'b0;
          edg_d   = '0;
          tmr_d   = TMR_LOAD;
          state_d = WAIT_FRAME;
        end else begin
          trig_cnt_d = trig_cnt_q - 4'd1;
        end
      end

      WAIT_FRAME: begin
        // An edge outranks an expiring timer, so the last edge always ACKs.
        if (fall) begin
          if (edg_q == EDG_LAST) begin
            resp_go   = 1'b1;
            resp_code = ST_ACK;
          end else begin
            edg_d = edg_q + EDG_W'(1);
            tmr_d = TMR_LOAD;
          end
        end else if (tmr_q == '0) begin
          resp_go   = 1'b1;
          resp_code = ST_FRAME_TO;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      RESP: begin
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (resp_go) begin
      state_d      = RESP;
      resp_valid_d = 1'b1;
      resp_data_d  = resp_code;
      if ((resp_code != ST_ACK) && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      opc_q         <= 8'h00;
      code_q        <= 8'h00;
      tmr_q         <= '0;
      edg_q         <= '0;
      trig_cnt_q    <= 4'd0;
      previn_code_q <= 8'h00;
      trig_q        <= 1'b0;
      busy_q        <= 1'b0;
      resp_data_q   <= 8'h00;
      resp_valid_q  <= 1'b0;
      err_cnt_q     <= 8'h00;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      prev_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      opc_q         <= opc_d;
      code_q        <= code_d;
      tmr_q         <= tmr_d;
      edg_q         <= edg_d;
      trig_cnt_q    <= trig_cnt_d;
      previn_code_q <= previn_code_d;
      trig_q        <= trig_d;
      busy_q        <= busy_d;
      resp_data_q   <= resp_data_d;
      resp_valid_q  <= resp_valid_d;
      err_cnt_q     <= err_cnt_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
    end
  end

  assign previn_code = previn_code_q;
  assign previn_trig = trig_q;
  assign busy        = busy_q;
  assign resp_data   = resp_data_q;
  assign resp_valid  = resp_valid_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_previn_cmd_ctrl.sv
// Directed bench for previn_cmd_ctrl: a table of host commands with expected
// status, code and error count, plus hand sequences for timeouts and reset.
module tb_previn_cmd_ctrl;

  localparam int TW = 4;
  localparam int FL = 9;
  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       fdata_G = 1'b0;
  logic [7:0] previn_code;
  logic       previn_trig;
  logic       busy;
  logic [7:0] resp_data;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [7:0] err_cnt;

  previn_cmd_ctrl #(
    .TRIG_WIDTH(TW),
    .FRAME_LEN (FL),
    .TIMEOUT   (TO),
    .HDR       (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fdata_G    (fdata_G),
    .previn_code(previn_code),
    .previn_trig(previn_trig),
    .busy       (busy),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int trig_total = 0;

  always @(negedge clk) if (previn_trig) trig_total <= trig_total + 1;

  typedef struct packed {
    logic [47:0] bytes;
    logic [3:0]  nb;
    logic [3:0]  edges;
    logic        glitch;
    logic        exp_trig;
    logic [7:0]  exp_code;
    logic [7:0]  exp_resp;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   tries;
    logic ok;
    rx_data  = b;
    rx_valid = 1'b1;
    tries    = 0;
    ok       = 1'b0;
    while (!ok && tries < 20) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      tries++;
    end
    #1 rx_valid = 1'b0;
    chk("rx_accept", 32'(ok), 32'd1);
  endtask

  task automatic pulse_edges(input int n);
    for (int i = 0; i < n; i++) begin
      fdata_G = 1'b1;
      repeat (3) @(posedge clk);
      #1 fdata_G = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 4 * TO) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic accept_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("resp_drop", 32'(resp_valid), 32'd0);
    chk("busy_drop", 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    int cyc;
    t0 = trig_total;
    for (int i = 0; i < 32'(v.nb); i++) send_byte(v.bytes[47 - 8*i -: 8]);
    chk("trig_n1", 32'(previn_trig), 32'(v.exp_trig));
    chk("busy_n1", 32'(busy), 32'(v.exp_trig));
    if (v.exp_trig) begin
      chk("code_n1", 32'(previn_code), 32'(v.exp_code));
      if (v.glitch) begin
        // three raw falls on fdata_G, all resolved while the strobe is high
        fdata_G = 1'b1; #1 fdata_G = 1'b0; #1 fdata_G = 1'b1;
        @(posedge clk);
        #1 fdata_G = 1'b0; #1 fdata_G = 1'b1; #1 fdata_G = 1'b0;
      end
      repeat (TW + 2) @(posedge clk);
      #1;
      chk("trig_low", 32'(previn_trig), 32'd0);
    end
    if (v.edges != 4'd0) begin
      pulse_edges(32'(v.edges) - 1);
      chk("no_early_ack", 32'(resp_valid), 32'd0);
      pulse_edges(1);
    end
    wait_resp(cyc);
    chk("resp_seen", 32'(resp_valid), 32'd1);
    chk("resp_data", 32'(resp_data), 32'(v.exp_resp));
    chk("code", 32'(previn_code), 32'(v.exp_code));
    chk("trig_width", 32'(trig_total - t0), v.exp_trig ? 32'(TW) : 32'd0);
    chk("busy_resp", 32'(busy), 32'(v.exp_trig));
    accept_resp();
    chk("err_cnt", 32'(err_cnt), 32'(v.exp_err));
  endtask

  function automatic vec_t mk(input logic [47:0] b, input logic [3:0] nb,
                              input logic [3:0] edges, input logic glitch,
                              input logic trig, input logic [7:0] code,
                              input logic [7:0] resp, input logic [7:0] err);
    vec_t v;
    v.bytes = b; v.nb = nb; v.edges = edges; v.glitch = glitch;
    v.exp_trig = trig; v.exp_code = code; v.exp_resp = resp; v.exp_err = err;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (n_bad=%0d)", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    // bytes are listed first-sent in the top byte
    vecs[0] = mk(48'hA5013C3D_0000, 4'd4, 4'd9, 1'b0, 1'b1, 8'h3C, 8'h06, 8'd0);
    vecs[1] = mk(48'hA5013C00_0000, 4'd4, 4'd0, 1'b0, 1'b0, 8'h3C, 8'h15, 8'd1);
    vecs[2] = mk(48'hA5071017_0000, 4'd4, 4'd0, 1'b0, 1'b0, 8'h3C, 8'h16, 8'd2);
    vecs[3] = mk(48'hA5015554_0000, 4'd4, 4'd9, 1'b0, 1'b1, 8'h55, 8'h06, 8'd2);
    vecs[4] = mk(48'hA5020002_0000, 4'd4, 4'd9, 1'b0, 1'b1, 8'h55, 8'h06, 8'd2);
    vecs[5] = mk(48'h1122A503FFFC,  4'd6, 4'd9, 1'b1, 1'b1, 8'h00, 8'h06, 8'd2);
    vecs[6] = mk(48'hA5A5A500_0000, 4'd4, 4'd0, 1'b0, 1'b0, 8'h00, 8'h16, 8'd3);
    vecs[7] = mk(48'hA501FFFE_0000, 4'd4, 4'd9, 1'b0, 1'b1, 8'hFF, 8'h06, 8'd3);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_code", 32'(previn_code), 32'd0);
    chk("rst_trig", 32'(previn_trig), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", 32'(resp_data), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    rst = 1'b0;
    #1 chk("rx_ready_idle", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // byte timeout after a partial command
    send_byte(8'hA5);
    send_byte(8'h01);
    wait_resp(cyc);
    chk("byte_to_seen", 32'(resp_valid), 32'd1);
    chk("byte_to_data", 32'(resp_data), 32'h17);
    chk("byte_to_lat_lo", 32'(cyc >= TO - 1), 32'd1);
    chk("byte_to_lat_hi", 32'(cyc <= TO + 1), 32'd1);
    chk("byte_to_busy", 32'(busy), 32'd0);
    accept_resp();
    chk("byte_to_err", 32'(err_cnt), 32'd4);

    // frame timeout with fdata_G static; response held while the host stalls
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h0F); send_byte(8'h0E);
    chk("fto_trig", 32'(previn_trig), 32'd1);
    wait_resp(cyc);
    chk("fto_seen", 32'(resp_valid), 32'd1);
    chk("fto_data", 32'(resp_data), 32'h18);
    chk("fto_lat_lo", 32'(cyc >= TO + 3), 32'd1);
    chk("fto_lat_hi", 32'(cyc <= TO + 7), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("fto_hold_valid", 32'(resp_valid), 32'd1);
    chk("fto_hold_data", 32'(resp_data), 32'h18);
    chk("fto_hold_busy", 32'(busy), 32'd1);
    chk("fto_code", 32'(previn_code), 32'h0F);
    accept_resp();
    chk("fto_err", 32'(err_cnt), 32'd5);

    // reset in the middle of a frame wait
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h77); send_byte(8'h76);
    repeat (10) @(posedge clk);
    #1;
    pulse_edges(2);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_code", 32'(previn_code), 32'd0);
    chk("mrst_trig", 32'(previn_trig), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_rvalid", 32'(resp_valid), 32'd0);
    chk("mrst_rdata", 32'(resp_data), 32'd0);
    chk("mrst_err", 32'(err_cnt), 32'd0);
    chk("mrst_rx_ready", 32'(rx_ready), 32'd0);
    rst = 1'b0;
    #1 chk("mrst_rx_ready_rel", 32'(rx_ready), 32'd1);
    run_vec(mk(48'hA5013C3D_0000, 4'd4, 4'd9, 1'b0, 1'b1, 8'h3C, 8'h06, 8'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
